// File: rtl/arith_pipe_pkg.sv
// Shared definitions for arith_pipe_unit: op encodings and the operation evaluator.
// Build option: ARITH_PIPE_SAT_EN makes add/sub saturate instead of wrapping.
package arith_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Widest operand supported; callers zero-extend and keep the low W bits.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = 7;

  // Returns {ovf, y} with y in the low MAX_W bits, masked to w bits.
  function automatic logic [MAX_W:0] alu_eval(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [1:0]       op,
                                               input int unsigned      w);
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] diff;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] y;
    logic             ovf;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    sum  = {1'b0, a} + {1'b0, b};
    diff = a - b;
    y    = '0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        y   = sum[MAX_W-1:0] & mask;
        ovf = sum[IDX_W'(w)];
`ifdef ARITH_PIPE_SAT_EN
        if (ovf) y = mask;
`endif
      end
      OP_SUB: begin
        y   = diff & mask;
        ovf = (a < b);
`ifdef ARITH_PIPE_SAT_EN
        if (ovf) y = '0;
`endif
      end
      OP_AND:  y = a & b;
      default: y = a ^ b;
    endcase
    return {ovf, y};
  endfunction

endpackage

// File: rtl/arith_pipe_unit_if.sv
// Operand/result handshake bundle for arith_pipe_unit; slave is the unit side.
interface arith_pipe_unit_if #(
  parameter int unsigned W     = 12,
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic             ovf;
  logic [CNT_W-1:0] out_count;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, ovf, out_count
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, ovf, out_count
  );
endinterface

// File: rtl/arith_pipe_stage.sv
// One pipeline slot: valid bit plus {ovf, y} payload, loaded on in_adv, drained on out_adv.
module arith_pipe_stage #(
  parameter int unsigned DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_adv_i,
  input  logic          out_adv_i,
  input  logic [DW-1:0] d_i,
  output logic          v_o,
  output logic [DW-1:0] q_o
);

  logic          v_d, v_q;
  logic [DW-1:0] q_d, q_q;

  // Load wins over drain so a simultaneous refill keeps the slot occupied.
  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (in_adv_i) begin
      v_d = 1'b1;
      q_d = d_i;
    end else if (out_adv_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v_o = v_q;
  assign q_o = q_q;

endmodule

// File: rtl/arith_pipe_unit.sv
// STAGES-deep two-operand arithmetic pipeline with valid/ready, flush and result counter.
// Build option: ARITH_PIPE_SAT_EN (saturating add/sub, handled in arith_pipe_pkg).
module arith_pipe_unit
  import arith_pipe_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  arith_pipe_unit_if.slave bus
);

  localparam int unsigned DW   = W + 1;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [DW-1:0]     stage_q [STAGES];
  logic [MAX_W:0]    res;
  logic [DW-1:0]     eval;
  logic              drain;
  logic              accept;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    res  = alu_eval(MAX_W'(bus.a), MAX_W'(bus.b), bus.op, W);
    eval = {res[MAX_W], W'(res)};
  end

  assign drain       = bus.out_ready & ~bus.flush;
  assign bus.in_ready = ~bus.flush & (~v_q[0] | adv[0]);
  assign accept      = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          in_adv;
    logic [DW-1:0] d;

    // Unrolled ready chain: a stage moves if any later slot is empty or the tail drains.
    if (k == LAST) begin : g_tail
      assign adv[k] = v_q[k] & drain;
    end else begin : g_mid
      assign adv[k] = v_q[k] & (~(&v_q[LAST:k+1]) | drain);
    end

    if (k == 0) begin : g_head
      assign in_adv = accept;
      assign d      = eval;
    end else begin : g_body
      assign in_adv = adv[k-1];
      assign d      = stage_q[k-1];
    end

    arith_pipe_stage #(.DW(DW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (bus.flush),
      .in_adv_i  (in_adv),
      .out_adv_i (adv[k]),
      .d_i       (d),
      .v_o       (v_q[k]),
      .q_o       (stage_q[k])
    );
  end

  // Completed-handshake counter; survives flush, wraps naturally.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(adv[LAST]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.out_valid = v_q[LAST] & ~bus.flush;
  assign bus.y         = stage_q[LAST][W-1:0];
  assign bus.ovf       = stage_q[LAST][W];
  assign bus.out_count = cnt_q;

endmodule
